// File: rtl/mpadd_arbiter.sv
// mpadd_arbiter: shares one registered WIDTH-bit adder between two requesters and
// returns each sum tagged with its requester ID. Define MPADD_ARB_FIXED_PRIO_EN for fixed priority.
module mpadd_arbiter #(
  parameter int WIDTH = 1029,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_sum,
  output logic             add_reset,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_result
);

  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH:0]   rsp_sum_q, rsp_sum_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             add_reset_q, add_reset_d;
  logic             grant0, grant1;
`ifdef MPADD_ARB_FIXED_PRIO_EN
`else
  logic             last_q, last_d;
`endif

  // Grants only while idle and the adder is out of reset; at most one port wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !add_reset_q) begin
`ifdef MPADD_ARB_FIXED_PRIO_EN
      if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
`else
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    add_reset_d = 1'b0;
`ifdef MPADD_ARB_FIXED_PRIO_EN
`else
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          add_a_d  = grant1 ? req1_a : req0_a;
          add_b_d  = grant1 ? req1_b : req0_b;
          rsp_id_d = grant1;
          cnt_d    = CNT_W'(LAT);
          state_d  = WAIT;
`ifdef MPADD_ARB_FIXED_PRIO_EN
`else
          last_d   = grant1;
`endif
        end
      end
      // Operands stay on the adder for LAT cycles; the sum is sampled in CAPT.
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPT: begin
        rsp_sum_d   = add_result;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_sum_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      add_reset_q <= 1'b1;
`ifdef MPADD_ARB_FIXED_PRIO_EN
`else
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      add_reset_q <= add_reset_d;
`ifdef MPADD_ARB_FIXED_PRIO_EN
`else
      last_q      <= last_d;
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_sum    = rsp_sum_q;
  assign add_reset  = add_reset_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;

endmodule

// File: tb/tb_mpadd_arbiter.sv
// tb_mpadd_arbiter: directed bench for mpadd_arbiter with a one-stage adder model
// and a scoreboard of expected {id, sum} responses.
module tb_mpadd_arbiter;

  localparam int WIDTH = 1029;
  localparam int LAT   = 1;

  typedef struct packed {
    logic           id;
    logic [WIDTH:0] sum;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid, req1_valid, rsp_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready, rsp_valid, rsp_id, add_reset;
  logic [WIDTH:0]   rsp_sum, add_result;
  logic [WIDTH-1:0] add_a, add_b;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared adder: one pipeline register, synchronous reset.
  always @(posedge clk) begin
    if (add_reset) add_result <= '0;
    else           add_result <= {1'b0, add_a} + {1'b0, add_b};
  end

  mpadd_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .add_reset(add_reset), .add_a(add_a), .add_b(add_b), .add_result(add_result)
  );

  task automatic checkOutput(input string tag, input logic [WIDTH:0] observed,
                             input logic [WIDTH:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed hi=%h lo=%h expected hi=%h lo=%h", tag,
             observed[WIDTH:WIDTH-63], observed[63:0], expected[WIDTH:WIDTH-63], expected[63:0]);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (port == 0) begin
      req0_valid = valid; req0_a = a; req0_b = b;
    end else begin
      req1_valid = valid; req1_a = a; req1_b = b;
    end
  endtask

  task automatic pushExpected(input int id, input logic [WIDTH:0] sum);
    exp_t e;
    e.id  = 1'(id);
    e.sum = sum;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns the granted port and idle cycles waited.
  task automatic waitGrant(input string tag, output int port, output int waited);
    logic got;
    got    = 1'b0;
    port   = -1;
    waited = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        checkOutput({tag, "_one_hot"}, req0_ready & req1_ready, 0);
        port = req1_ready ? 1 : 0;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    checkOutput({tag, "_grant_seen"}, got, 1);
  endtask

  // Called in the acceptance cycle; rsp_valid must rise LAT+2 cycles later.
  task automatic waitResponse(input string tag);
    int   k;
    logic seen;
    exp_t e;
    k    = 0;
    seen = 1'b0;
    while (k < 60 && !seen) begin
      @(negedge clk);
      k++;
      seen = rsp_valid;
    end
    checkOutput({tag, "_rsp_seen"}, seen, 1);
    checkOutput({tag, "_latency"}, k, LAT + 2);
    checkOutput({tag, "_sb_pending"}, sb.size() > 0, 1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_rsp_id"}, rsp_id, e.id);
      checkOutput({tag, "_rsp_sum"}, rsp_sum, e.sum);
    end
  endtask

  task automatic runOp(input string tag, input int p, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH:0] s);
    int gp, gw;
    pushExpected(p, s);
    applyStimulus(p, 1'b1, a, b);
    waitGrant(tag, gp, gw);
    checkOutput({tag, "_grant_port"}, gp, p);
    @(posedge clk); #1;
    applyStimulus(p, 1'b0, '0, '0);
    waitResponse(tag);
    @(negedge clk);
    checkOutput({tag, "_rsp_cleared"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] va, vb;
    logic [WIDTH:0]   vs;
    logic [WIDTH-1:0] op_a [2];
    logic [WIDTH-1:0] op_b [2];
    int               port, waited, last_cyc, g;
    int               exp_grant [4];

    rsp_ready = 1'b1;
    applyStimulus(0, 1'b1, 1, 2);
    applyStimulus(1, 1'b0, '0, '0);

    // Reset values while reset is held and req0 is already valid.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_add_reset", add_reset, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_sum", rsp_sum, 0);
    checkOutput("rst_add_a", add_a, 0);
    checkOutput("rst_add_b", add_b, 0);
    checkOutput("rst_req0_ready", req0_ready, 0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rel_add_reset_still_high", add_reset, 1);
    checkOutput("rel_no_ready", req0_ready, 0);
    @(negedge clk);
    checkOutput("rel_add_reset_cleared", add_reset, 0);
    pushExpected(0, 3);
    waitGrant("op1", port, waited);
    checkOutput("op1_grant_port", port, 0);
    checkOutput("op1_first_cycle", waited, 0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, '0, '0);
    waitResponse("op1");
    @(negedge clk);
    checkOutput("op1_rsp_cleared", rsp_valid, 0);

    // All-ones operands: carry-out must land in bit WIDTH.
    va = '1;
    vs = {{WIDTH{1'b1}}, 1'b0};
    pushExpected(1, vs);
    applyStimulus(1, 1'b1, va, va);
    waitGrant("allones", port, waited);
    checkOutput("allones_grant_port", port, 1);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, '0, '0);
    waitResponse("allones");
    checkOutput("allones_top_bit", rsp_sum[WIDTH], 1);
    @(negedge clk);

    va = '0; va[127:0] = '1;
    vb = 1;
    vs = '0; vs[128] = 1'b1;
    runOp("carry128", 1, va, vb, vs);

    // Both requesters valid continuously.
`ifdef MPADD_ARB_FIXED_PRIO_EN
    exp_grant = '{0, 0, 0, 0};
`else
    exp_grant = '{0, 1, 0, 1};
`endif
    op_a[0] = 10;  op_b[0] = 20;
    op_a[1] = 100; op_b[1] = 200;
    applyStimulus(0, 1'b1, op_a[0], op_b[0]);
    applyStimulus(1, 1'b1, op_a[1], op_b[1]);
    last_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      g = exp_grant[i];
      pushExpected(g, {1'b0, op_a[g]} + {1'b0, op_b[g]});
      waitGrant("alt", port, waited);
      checkOutput("alt_grant_order", port, g);
      if (i > 0) checkOutput("alt_throughput", cyc - last_cyc, LAT + 3);
      last_cyc = cyc;
      @(posedge clk); #1;
      op_a[g] = op_a[g] + 7;
      applyStimulus(g, 1'b1, op_a[g], op_b[g]);
      waitResponse("alt");
      @(negedge clk);
    end
    applyStimulus(0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, '0, '0);
    checkOutput("alt_rsp_cleared", rsp_valid, 0);

    // Back-pressure: response held while req1 waits for the handshake.
    @(negedge clk);
    rsp_ready = 1'b0;
    pushExpected(0, 11);
    applyStimulus(0, 1'b1, 5, 6);
    waitGrant("stall", port, waited);
    checkOutput("stall_grant_port", port, 0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, '0, '0);
    pushExpected(1, 15);
    applyStimulus(1, 1'b1, 7, 8);
    waitResponse("stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_hold_valid", rsp_valid, 1);
      checkOutput("stall_hold_sum", rsp_sum, 11);
      checkOutput("stall_hold_id", rsp_id, 0);
      checkOutput("stall_no_ready1", req1_ready, 0);
      checkOutput("stall_no_ready0", req0_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("stall_no_grant_in_handshake", req1_ready, 0);
    @(negedge clk);
    waitGrant("stall_req1", port, waited);
    checkOutput("stall_req1_port", port, 1);
    checkOutput("stall_req1_after_handshake", waited, 0);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, '0, '0);
    waitResponse("stall_req1");
    @(negedge clk);

    // Reset while an operation is in WAIT.
    applyStimulus(1, 1'b1, 9, 9);
    waitGrant("midrst", port, waited);
    checkOutput("midrst_grant_port", port, 1);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, '0, '0);
    checkOutput("midrst_inflight_add_a", add_a, 9);
    checkOutput("midrst_inflight_id", rsp_id, 1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_rsp_id", rsp_id, 0);
    checkOutput("midrst_rsp_sum", rsp_sum, 0);
    checkOutput("midrst_add_a", add_a, 0);
    checkOutput("midrst_add_b", add_b, 0);
    checkOutput("midrst_add_reset", add_reset, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_rsp", rsp_valid, 0);
    end
    reset = 1'b0;
    runOp("post_reset", 0, 11, 22, 33);

    checkOutput("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
